// File: rtl/jogo_memoria_param.sv
// Sequence-memory game core: FSM plus sequence RAM, round/position counters,
// button edge detector, playback and timeout timers.
module jogo_memoria_param #(
  parameter int unsigned NUM_BOTOES     = 4,
  parameter int unsigned MAX_RODADAS    = 16,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned T_MOSTRA       = 1000,
  localparam int unsigned AW            = $clog2(MAX_RODADAS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [NUM_BOTOES-1:0] botoes,
  input  logic                  modo_grava,
  input  logic                  dificuldade,
  input  logic                  mem_we,
  input  logic [AW-1:0]         mem_addr,
  input  logic [NUM_BOTOES-1:0] mem_dado,
  output logic                  acertou,
  output logic                  errou,
  output logic                  timeout,
  output logic                  pronto,
  output logic [NUM_BOTOES-1:0] leds,
  output logic [3:0]            db_estado,
  output logic [AW-1:0]         db_rodada,
  output logic [AW-1:0]         db_posicao
);

  localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int unsigned MW = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;
  localparam logic [TW-1:0] TMO_FIM   = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [MW-1:0] MOSTRA_FIM = MW'(T_MOSTRA - 1);
  localparam logic [AW-1:0] ULT_CURTO = AW'(MAX_RODADAS / 2 - 1);
  localparam logic [AW-1:0] ULT_LONGO = AW'(MAX_RODADAS - 1);

  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPrepara    = 4'h1,
    StMostra     = 4'h2,
    StEspera     = 4'h3,
    StRegistra   = 4'h4,
    StCompara    = 4'h5,
    StProxima    = 4'h6,
    StFimRodada  = 4'h7,
    StEsperaNova = 4'h8,
    StGrava      = 4'h9,
    StFimAcerto  = 4'hA,
    StFimErro    = 4'hB,
    StFimTimeout = 4'hC
  } estado_t;

  estado_t estado_q, estado_d;

  logic [NUM_BOTOES-1:0] mem [MAX_RODADAS];
  logic [NUM_BOTOES-1:0] jogada_q;
  logic [NUM_BOTOES-1:0] botoes_prev_q;
  logic [AW-1:0]         rodada_q, posicao_q;
  logic [TW-1:0]         tmo_q;
  logic [MW-1:0]         mostra_q;
  logic                  modo_q, dif_q;

  logic jogada, jogada_nova, fim_mostra, ultimo, ultima_rodada, tmo_fim, ocioso;

  assign jogada        = (|botoes) & ~(|botoes_prev_q);
  assign jogada_nova   = jogada & $onehot(botoes);
  assign fim_mostra    = (mostra_q == MOSTRA_FIM);
  assign ultimo        = (posicao_q == rodada_q);
  assign ultima_rodada = (rodada_q == (dif_q ? ULT_LONGO : ULT_CURTO));
  assign tmo_fim       = (tmo_q == TMO_FIM);
  assign ocioso        = estado_q inside {StInicial, StFimAcerto, StFimErro, StFimTimeout};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= StInicial;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial, StFimAcerto, StFimErro, StFimTimeout: if (iniciar) estado_d = StPrepara;
      StPrepara:  estado_d = StMostra;
      StMostra:   if (fim_mostra && ultimo) estado_d = StEspera;
      StEspera: begin
        // A press on the terminal-count cycle takes priority over the timeout.
        if (jogada)       estado_d = StRegistra;
        else if (tmo_fim) estado_d = StFimTimeout;
      end
      StRegistra: estado_d = StCompara;
      StCompara: begin
        if (jogada_q != mem[posicao_q]) estado_d = StFimErro;
        else if (ultimo)                estado_d = StFimRodada;
        else                            estado_d = StProxima;
      end
      StProxima:  estado_d = StEspera;
      StFimRodada: begin
        if (ultima_rodada) estado_d = StFimAcerto;
        else if (modo_q)   estado_d = StEsperaNova;
        else               estado_d = StMostra;
      end
      StEsperaNova: begin
        if (jogada_nova)  estado_d = StGrava;
        else if (tmo_fim) estado_d = StFimTimeout;
      end
      StGrava:    estado_d = StMostra;
      default:    estado_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoes_prev_q <= '0;
      jogada_q      <= '0;
      rodada_q      <= '0;
      posicao_q     <= '0;
      tmo_q         <= '0;
      mostra_q      <= '0;
      modo_q        <= 1'b0;
      dif_q         <= 1'b0;
    end else begin
      botoes_prev_q <= botoes;
      if (estado_q == StEspera || estado_q == StEsperaNova) tmo_q <= tmo_q + TW'(1);
      else                                                  tmo_q <= '0;
      case (estado_q)
        StPrepara: begin
          modo_q    <= modo_grava;
          dif_q     <= dificuldade;
          rodada_q  <= '0;
          posicao_q <= '0;
          jogada_q  <= '0;
          mostra_q  <= '0;
        end
        StMostra: begin
          if (fim_mostra) begin
            mostra_q <= '0;
            if (ultimo) begin
              posicao_q <= '0;
              jogada_q  <= '0;
            end else begin
              posicao_q <= posicao_q + AW'(1);
            end
          end else begin
            mostra_q <= mostra_q + MW'(1);
          end
        end
        StRegistra: jogada_q  <= botoes;
        StProxima:  posicao_q <= posicao_q + AW'(1);
        StFimRodada: begin
          if (!ultima_rodada && !modo_q) begin
            rodada_q  <= rodada_q + AW'(1);
            posicao_q <= '0;
          end
        end
        StEsperaNova: if (jogada_nova) jogada_q <= botoes;
        StGrava: begin
          rodada_q  <= rodada_q + AW'(1);
          posicao_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sequence RAM survives reset; the host port is only open while no game runs.
  always_ff @(posedge clock) begin
    if (mem_we && ocioso)          mem[mem_addr] <= mem_dado;
    else if (estado_q == StGrava)  mem[rodada_q + AW'(1)] <= jogada_q;
  end

  assign acertou    = (estado_q == StFimAcerto);
  assign errou      = (estado_q == StFimErro) || (estado_q == StFimTimeout);
  assign timeout    = (estado_q == StFimTimeout);
  assign pronto     = ocioso && (estado_q != StInicial);
  assign leds       = (estado_q == StMostra) ? mem[posicao_q] : jogada_q;
  assign db_estado  = estado_q;
  assign db_rodada  = rodada_q;
  assign db_posicao = posicao_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: playback and end-of-game results are
// predicted into queues and checked as the DUT produces them.
module tb_jogo_memoria_param;

  localparam int unsigned NB = 4;
  localparam int unsigned MR = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned TM = 2;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset, iniciar, modo_grava, dificuldade, mem_we;
  logic [NB-1:0] botoes, mem_dado, leds;
  logic [AW-1:0] mem_addr, db_rodada, db_posicao;
  logic          acertou, errou, timeout, pronto;
  logic [3:0]    db_estado;

  jogo_memoria_param #(
    .NUM_BOTOES    (NB),
    .MAX_RODADAS   (MR),
    .TIMEOUT_CICLOS(TO),
    .T_MOSTRA      (TM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .botoes     (botoes),
    .modo_grava (modo_grava),
    .dificuldade(dificuldade),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_dado   (mem_dado),
    .acertou    (acertou),
    .errou      (errou),
    .timeout    (timeout),
    .pronto     (pronto),
    .leds       (leds),
    .db_estado  (db_estado),
    .db_rodada  (db_rodada),
    .db_posicao (db_posicao)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [NB-1:0] mdl [MR];
  logic [NB-1:0] novos [MR];
  logic [NB-1:0] play_q [$];
  logic [11:0]   fim_q [$];
  logic          pronto_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] fim_word(input logic [3:0] st, input logic a, input logic e,
                                           input logic t, input logic [AW-1:0] r,
                                           input logic [AW-1:0] p);
    return {st, a, e, t, 1'b1, r, p};
  endfunction

  // Playback scoreboard: every cycle spent in MOSTRA consumes one predicted led value.
  always @(negedge clock) begin
    if (!reset && db_estado == 4'h2) begin
      if (play_q.size() == 0) check_val("play_extra", 32'(play_q.size()), 32'd1);
      else                    check_val("play", 32'(leds), 32'(play_q.pop_front()));
    end
  end

  // End-of-game scoreboard, compared when pronto rises.
  always @(negedge clock) begin
    if (pronto && !pronto_prev) begin
      if (fim_q.size() == 0) check_val("fim_extra", 32'(fim_q.size()), 32'd1);
      else check_val("fim", 32'({db_estado, acertou, errou, timeout, pronto, db_rodada,
                                 db_posicao}), 32'(fim_q.pop_front()));
    end
    pronto_prev <= pronto;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_estado(input logic [3:0] st, input string tag);
    int k = 0;
    while (db_estado !== st && k < 200) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(db_estado), 32'(st));
  endtask

  task automatic press(input logic [NB-1:0] b);
    botoes = b;
    tick(2);
    botoes = '0;
    tick(1);
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [NB-1:0] d);
    mem_we = 1'b1; mem_addr = a; mem_dado = d;
    tick(1);
    mem_we = 1'b0;
  endtask

  task automatic start(input logic dif, input logic modo);
    dificuldade = dif; modo_grava = modo; iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  task automatic push_round(input int r);
    for (int i = 0; i <= r; i++) repeat (TM) play_q.push_back(mdl[i]);
  endtask

  task automatic play_round(input int r);
    for (int i = 0; i <= r; i++) begin
      wait_estado(4'h3, "espera");
      press(mdl[i]);
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; modo_grava = 1'b0; dificuldade = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_dado = '0; botoes = '0;
    novos[0] = 4'h0; novos[1] = 4'h8; novos[2] = 4'h4; novos[3] = 4'h1;
    tick(2);
    check_val("reset_outs", 32'({db_estado, acertou, errou, timeout, pronto, leds, db_rodada,
                                db_posicao}), 32'd0);
    reset = 1'b0;
    tick(1);

    // Full game, long difficulty, fixed sequence 1,2,4,8.
    for (int i = 0; i < MR; i++) begin
      mdl[i] = NB'(1 << i);
      write_mem(AW'(i), mdl[i]);
    end
    for (int r = 0; r < MR; r++) push_round(r);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3));
    start(1'b1, 1'b0);
    for (int r = 0; r < MR; r++) play_round(r);
    tick(1);
    check_val("t1_estado", 32'(db_estado), 32'hA);
    check_val("t1_leds", 32'(leds), 32'h8);

    // Wrong move at round 1, position 1: three-cycle latency to FIM_ERRO.
    push_round(0); push_round(1);
    fim_q.push_back(fim_word(4'hB, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1));
    start(1'b1, 1'b0);
    play_round(0);
    wait_estado(4'h3, "t2_espera");
    press(mdl[0]);
    wait_estado(4'h3, "t2_espera2");
    botoes = 4'b0100;
    tick(2);
    check_val("t2_lat2", 32'(db_estado), 32'h5);
    botoes = '0;
    tick(1);
    check_val("t2_lat3", 32'(db_estado), 32'hB);
    check_val("t2_leds", 32'(leds), 32'h4);

    // Short difficulty wins after two rounds; then a timeout.
    push_round(0); push_round(1);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1));
    start(1'b0, 1'b0);
    play_round(0); play_round(1);
    tick(1);
    check_val("t3_curto", 32'(db_estado), 32'hA);
    push_round(0);
    fim_q.push_back(fim_word(4'hC, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
    start(1'b0, 1'b0);
    wait_estado(4'h3, "t3_espera");
    check_val("t3_leds_espera", 32'(leds), 32'h0);
    tick(TO - 1);
    check_val("t3_pre_tmo", 32'(db_estado), 32'h3);
    tick(1);
    check_val("t3_tmo", 32'(db_estado), 32'hC);

    // Record mode: moves 8,4,1 appended after each round; 0110 is ignored.
    mdl[0] = 4'h2;
    write_mem(2'd0, mdl[0]);
    push_round(0);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3));
    start(1'b1, 1'b1);
    play_round(0);
    wait_estado(4'h8, "t4_nova");
    press(4'b0110);
    check_val("t4_ignora", 32'(db_estado), 32'h8);
    for (int r = 1; r < MR; r++) begin
      wait_estado(4'h8, "t4_nova_r");
      mdl[r] = novos[r];
      push_round(r);
      press(mdl[r]);
      play_round(r);
    end
    tick(1);
    check_val("t4_fim", 32'(db_estado), 32'hA);

    // Reset during playback of round 2, then replay the same RAM.
    push_round(0); push_round(1); push_round(2);
    start(1'b1, 1'b0);
    play_round(0); play_round(1);
    wait_estado(4'h2, "t5_mostra");
    tick(1);
    reset = 1'b1;
    play_q.delete();
    #1;
    check_val("t5_reset", 32'({db_estado, acertou, errou, timeout, pronto, leds, db_rodada,
                              db_posicao}), 32'd0);
    tick(1);
    reset = 1'b0;
    for (int r = 0; r < MR; r++) push_round(r);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3));
    start(1'b1, 1'b0);
    for (int r = 0; r < MR; r++) play_round(r);
    tick(1);
    check_val("t5_replay", 32'(db_estado), 32'hA);

    // RAM writes ignored mid-game, honoured together with iniciar from FIM_ERRO.
    push_round(0); push_round(1);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1));
    start(1'b0, 1'b0);
    wait_estado(4'h3, "t6_espera");
    write_mem(2'd0, 4'h4);
    play_round(0); play_round(1);
    tick(1);
    check_val("t6_we_ignorado", 32'(db_estado), 32'hA);
    push_round(0);
    fim_q.push_back(fim_word(4'hB, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    start(1'b0, 1'b0);
    wait_estado(4'h3, "t6_espera2");
    press(4'b0001);
    check_val("t6_erro", 32'(db_estado), 32'hB);
    mdl[0] = 4'h4;
    push_round(0); push_round(1);
    fim_q.push_back(fim_word(4'hA, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1));
    mem_we = 1'b1; mem_addr = 2'd0; mem_dado = 4'h4;
    dificuldade = 1'b0; modo_grava = 1'b0; iniciar = 1'b1;
    tick(1);
    mem_we = 1'b0; iniciar = 1'b0;
    play_round(0); play_round(1);
    tick(1);
    check_val("t6_we_inicio", 32'(db_estado), 32'hA);

    tick(3);
    check_val("play_left", 32'(play_q.size()), 32'd0);
    check_val("fim_left", 32'(fim_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
